// File: rtl/scoreboard_issue_gate.sv
// Decode-to-execute issue gate: holds one instruction until its sources and destination are free on the scoreboard.
// One cycle minimum accept-to-issue, refill in the issue cycle; a hazard or out_ready low holds the entry and drops in_ready.
module scoreboard_issue_gate #(
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_ir,
  input  logic [15:0]                in_pc,
  input  logic [2:0]                 in_sr1,
  input  logic [2:0]                 in_sr2,
  input  logic [2:0]                 in_dr,
  input  logic                       in_uses_sr1,
  input  logic                       in_uses_sr2,
  input  logic                       in_writes_dr,
  input  logic [7:0]                 sb_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_ir,
  output logic [15:0]                out_pc,
  output logic [2:0]                 out_dr,
  output logic                       out_writes_dr,
  output logic                       claim,
  output logic [2:0]                 claim_idx,
  input  logic                       flush,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic        uses_sr1;
    logic        uses_sr2;
    logic        writes_dr;
  } entry_t;

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state;
  state_t                     state_next;
  entry_t                     entry;
  logic                       hazard;
  logic                       issue;
  logic                       accept;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // The dr term blocks WAW; a self-dependency is fine because the claim lands only after issue.
  always_comb begin
    state_next = state;
    hazard     = 1'b0;
    out_valid  = 1'b0;
    issue      = 1'b0;
    in_ready   = 1'b0;
    accept     = 1'b0;
    claim      = 1'b0;
    if (state == FULL) begin
      hazard = (entry.uses_sr1  && !sb_ready[entry.sr1]) ||
               (entry.uses_sr2  && !sb_ready[entry.sr2]) ||
               (entry.writes_dr && !sb_ready[entry.dr]);
    end
    out_valid = (state == FULL) && !hazard && !flush;
    issue     = out_valid && out_ready;
    in_ready  = !flush && ((state == EMPTY) || issue);
    accept    = in_valid && in_ready;
    claim     = issue && entry.writes_dr;
    if (flush)       state_next = EMPTY;
    else if (accept) state_next = FULL;
    else if (issue)  state_next = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry <= '0;
    end else if (accept) begin
      entry <= '{ir: in_ir, pc: in_pc, sr1: in_sr1, sr2: in_sr2, dr: in_dr,
                 uses_sr1: in_uses_sr1, uses_sr2: in_uses_sr2, writes_dr: in_writes_dr};
    end
  end

  // Backpressure and flush cycles are not hazard stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == FULL) && hazard && !flush && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign out_ir        = entry.ir;
  assign out_pc        = entry.pc;
  assign out_dr        = entry.dr;
  assign out_writes_dr = entry.writes_dr;
  assign claim_idx     = entry.dr;
  assign stall_count   = stall_cnt;

endmodule

// File: tb/tb_scoreboard_issue_gate.sv
// Bench for scoreboard_issue_gate: expected issues are queued by the stimulus and checked by a negedge monitor.
module tb_scoreboard_issue_gate;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ir;
  logic [15:0] in_pc;
  logic [2:0]  in_sr1;
  logic [2:0]  in_sr2;
  logic [2:0]  in_dr;
  logic        in_uses_sr1;
  logic        in_uses_sr2;
  logic        in_writes_dr;
  logic [7:0]  sb_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ir;
  logic [15:0] out_pc;
  logic [2:0]  out_dr;
  logic        out_writes_dr;
  logic        claim;
  logic [2:0]  claim_idx;
  logic        flush;
  logic [3:0]  stall_count;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [2:0]  dr;
    logic        w;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;

  scoreboard_issue_gate #(.STALL_CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr),
    .in_uses_sr1(in_uses_sr1), .in_uses_sr2(in_uses_sr2), .in_writes_dr(in_writes_dr),
    .sb_ready(sb_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc(out_pc), .out_dr(out_dr), .out_writes_dr(out_writes_dr),
    .claim(claim), .claim_idx(claim_idx),
    .flush(flush), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every accepted issue must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_failed++;
        $display("FAIL unexpected_issue: ir 0x%0h issued with nothing expected at %0t", out_ir, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_ir", out_ir, e.ir);
        chk("issue_pc", out_pc, e.pc);
        chk("issue_dr", out_dr, e.dr);
        chk("issue_writes_dr", out_writes_dr, e.w);
        chk("issue_claim", claim, e.w);
        chk("issue_claim_idx", claim_idx, e.dr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] ir, input logic [15:0] pc,
                     input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                     input logic u1, input logic u2, input logic w, input bit will_issue);
    exp_t e;
    in_valid = 1'b1; in_ir = ir; in_pc = pc;
    in_sr1 = s1; in_sr2 = s2; in_dr = d;
    in_uses_sr1 = u1; in_uses_sr2 = u2; in_writes_dr = w;
    if (will_issue) begin
      e.ir = ir; e.pc = pc; e.dr = d; e.w = w;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; sb_ready = 8'hFF;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; sb_ready = 8'hFF;
    in_ir = '0; in_pc = '0; in_sr1 = '0; in_sr2 = '0; in_dr = '0;
    in_uses_sr1 = 1'b0; in_uses_sr2 = 1'b0; in_writes_dr = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_claim", claim, 0);
    chk("rst_claim_idx", claim_idx, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_out_ir", out_ir, 0);
    chk("rst_out_pc", out_pc, 0);
    tick();
    reset = 1'b0;
    tick();

    // Three independent instructions, back to back.
    put(16'h1261, 16'h3000, 3'd0, 3'd1, 3'd1, 1, 1, 1, 1);
    tick(); #3;
    chk("b2b_out_valid0", out_valid, 1);
    chk("b2b_in_ready0", in_ready, 1);
    put(16'h14A2, 16'h3002, 3'd2, 3'd3, 3'd2, 1, 1, 1, 1);
    tick(); #3;
    chk("b2b_out_valid1", out_valid, 1);
    put(16'h0402, 16'h3004, 3'd0, 3'd0, 3'd7, 0, 0, 0, 1);
    tick(); #3;
    chk("b2b_out_valid2", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("b2b_empty", out_valid, 0);
    chk("b2b_stall", stall_count, 0);

    // RAW on R3: claim at the issuing edge clears sb_ready[3] for four cycles.
    do_reset();
    put(16'h1642, 16'h3010, 3'd1, 3'd2, 3'd3, 1, 1, 1, 1);
    tick();
    put(16'h18E1, 16'h3012, 3'd3, 3'd1, 3'd4, 1, 0, 1, 1);
    tick();
    in_valid = 1'b0;
    sb_ready = 8'hF7;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("raw_stalled", out_valid, 0);
      chk("raw_no_claim", claim, 0);
      tick();
    end
    sb_ready = 8'hFF;
    #3;
    chk("raw_release_valid", out_valid, 1);
    chk("raw_stall4", stall_count, 4);
    tick();
    chk("raw_done", out_valid, 0);
    chk("raw_stall_kept", stall_count, 4);

    // WAW on R5 with sources ready.
    do_reset();
    sb_ready = 8'hDF;
    put(16'h1A42, 16'h3020, 3'd1, 3'd2, 3'd5, 1, 1, 1, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("waw_stalled", out_valid, 0);
      chk("waw_no_claim", claim, 0);
      tick();
    end
    sb_ready = 8'hFF;
    tick();
    chk("waw_stall2", stall_count, 2);

    // Backpressure: entry held, no claim, no stall counting, next instruction waits.
    do_reset();
    out_ready = 1'b0;
    put(16'h1DC3, 16'h3030, 3'd7, 3'd3, 3'd6, 1, 1, 1, 1);
    tick();
    put(16'h1E01, 16'h3032, 3'd0, 3'd1, 3'd7, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_claim", claim, 0);
      chk("bp_payload_ir", out_ir, 16'h1DC3);
      chk("bp_payload_dr", out_dr, 6);
      tick();
    end
    chk("bp_stall", stall_count, 0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_refill_ir", out_ir, 16'h1E01);
    tick();

    // Flush while FULL and hazard-free: flush beats issue and accept.
    do_reset();
    put(16'h1111, 16'h3040, 3'd0, 3'd0, 3'd1, 0, 0, 1, 0);
    tick();
    put(16'h1222, 16'h3042, 3'd2, 3'd3, 3'd1, 1, 1, 1, 1);
    flush = 1'b1;
    #3;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_claim", claim, 0);
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    #3;
    chk("fl_empty", out_valid, 0);
    chk("fl_in_ready_after", in_ready, 1);
    chk("fl_payload_kept", out_ir, 16'h1111);
    tick();
    in_valid = 1'b0;
    tick();

    // Saturation at 4'hF, then async reset between edges.
    do_reset();
    sb_ready = 8'hFB;
    put(16'h1082, 16'h3050, 3'd2, 3'd2, 3'd0, 1, 0, 1, 0);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_stall", stall_count, 4'hF);
    chk("sat_out_valid", out_valid, 0);
    sb_ready = 8'hFF;
    #1;
    chk("sat_released_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_claim", claim, 0);
    chk("arst_stall", stall_count, 0);
    chk("arst_in_ready", in_ready, 1);
    reset = 1'b0;
    tick();
    tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/scoreboard_issue_gate.md
# scoreboard_issue_gate

Issue gate between the decode and execute stages of the LC-3b pipeline. It holds one decoded instruction and checks its source and destination registers against the register scoreboard's ready vector. When the instruction is hazard-free it issues it downstream and drives the scoreboard claim port (write0/index0), which marks the destination busy. It is the consumer and claimer of scoreboard state; the writeback stage releases registers through the scoreboard's write1 port.

## Interface
Parameters:
- STALL_CNT_WIDTH, 16, width of the saturating hazard-stall counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  gate accepts the instruction this cycle
- in_ir  in  16  instruction word (lc3b_word)
- in_pc  in  16  instruction PC (lc3b_word)
- in_sr1, in_sr2, in_dr  in  3 each  register indices (lc3b_reg)
- in_uses_sr1, in_uses_sr2, in_writes_dr  in  1 each  operand-use flags
- sb_ready  in  8  scoreboard dataout; bit i = 1 means R[i] is available
- out_valid  out  1  issued instruction valid to execute
- out_ready  in  1  execute accepts
- out_ir, out_pc  out  16 each  held instruction and PC
- out_dr  out  3  held destination index
- out_writes_dr  out  1  held destination-write flag
- claim  out  1  to scoreboard write0
- claim_idx  out  3  to scoreboard index0
- flush  in  1  branch or exception squash
- stall_count  out  STALL_CNT_WIDTH  cycles spent blocked on a hazard

## Operation
- Two states: EMPTY and FULL. The entry register holds ir, pc, sr1, sr2, dr and the three use flags.
- hazard = FULL && ((uses_sr1 && !sb_ready[sr1]) || (uses_sr2 && !sb_ready[sr2]) || (writes_dr && !sb_ready[dr])). The dr term blocks WAW.
- out_valid = FULL && !hazard && !flush.
- issue = out_valid && out_ready.
- claim = issue && out_writes_dr; claim_idx = held dr. claim_idx is driven with held dr even when claim is 0.
- in_ready = !flush && (EMPTY || issue).
- Accept (in_valid && in_ready): the entry loads and the state is FULL next cycle. This allows back-to-back refill in the same cycle as an issue.
- Issue with no accept: the state goes FULL -> EMPTY.
- flush: the entry is invalidated at the next edge (state EMPTY). In the flush cycle there is no issue, no claim and no accept.
- stall_count: increments on each cycle with FULL && hazard && !flush. It saturates at all ones and is cleared only by reset.
- Payload outputs (out_ir, out_pc, out_dr, out_writes_dr) reflect the entry register and may change only on accept.

## Timing
- Reset values: state EMPTY, entry fields 0, out_valid 0, claim 0, claim_idx 0, in_ready 1, stall_count 0, all out_* payloads 0.
- Latency: an instruction accepted at edge N can issue in the cycle after edge N (one-cycle minimum decode-to-execute).
- Scoreboard feedback: a claim is registered by the scoreboard at the issuing edge. A dependent instruction loaded at that same edge sees its bit at 0 and stalls. No internal bypass exists.
- A writeback release (write1) is visible on sb_ready one cycle after its edge, so the stalled instruction issues in that cycle.
- Self-dependency (sr1 == dr, both used): this is not a hazard if the bit is 1, because the claim takes effect only after issue.
- out_ready low with no hazard: the entry holds, no claim is made, and stall_count does not increment (this is a backpressure stall, not a hazard).
- flush and issue conditions true together: flush wins.
- Asynchronous reset mid-stall: the state goes EMPTY immediately and any outstanding claim is dropped. The scoreboard itself is not reset by this block.

## Test plan
- Reset, then sb_ready=8'hFF and a stream of 3 independent instructions with out_ready=1 -> each issues one cycle after accept, back-to-back. There is one claim per writes_dr instruction with the correct claim_idx, and stall_count=0.
- RAW: issue ADD R3 (claim_idx=3), then ADD R4←R3 with sb_ready[3]=0 for 4 cycles, then 1 -> out_valid=0 for 4 cycles, issue on the 5th cycle, stall_count=4.
- WAW: dr=5 with sb_ready[5]=0 and sources ready -> no issue and no claim until sb_ready[5]=1.
- Backpressure: no hazard and out_ready=0 for 3 cycles -> out_valid=1 held, in_ready=0, claim=0, stall_count unchanged; the payload is stable.
- Flush while FULL and hazard-free with out_ready=1 -> no issue or claim that cycle, EMPTY next cycle, and the next instruction is accepted normally.
- Saturation with STALL_CNT_WIDTH=4: a hazard held for 20 cycles -> stall_count=4'hF. An asynchronous reset pulse mid-cycle clears it and out_valid immediately.
